// File: rtl/cjb_stack_arb_v_if.sv
// Bundle of requester, stack and status signals for the two-requester stack arbiter.
// master is the surrounding environment, slave is the arbiter itself.
interface cjb_stack_arb_v_if;
    logic       req0_push, req0_pop;
    logic [7:0] req0_din;
    logic       req1_push, req1_pop;
    logic [7:0] req1_din;
    logic       gnt0, gnt1;
    logic       flush, err_clr;
    logic       stk_push, stk_pop, stk_clr;
    logic [7:0] stk_din, stk_dout;
    logic [7:0] rd_data;
    logic       rd_valid, rd_id;
    logic [2:0] count;
    logic       full, empty;
    logic       ovf_err, unf_err;

    modport master (
        output req0_push, req0_pop, req0_din, req1_push, req1_pop, req1_din,
               flush, err_clr, stk_dout,
        input  gnt0, gnt1, stk_push, stk_pop, stk_clr, stk_din,
               rd_data, rd_valid, rd_id, count, full, empty, ovf_err, unf_err
    );

    modport slave (
        input  req0_push, req0_pop, req0_din, req1_push, req1_pop, req1_din,
               flush, err_clr, stk_dout,
        output gnt0, gnt1, stk_push, stk_pop, stk_clr, stk_din,
               rd_data, rd_valid, rd_id, count, full, empty, ovf_err, unf_err
    );
endinterface

// File: rtl/cjb_stack_arb_v.sv
// Round-robin arbiter sharing one external 8-bit stack between two requesters,
// tracking occupancy and sticky overflow/underflow errors.
module cjb_stack_arb_v #(
    parameter int DEPTH = 4
) (
    input logic               Clock,
    input logic               Reset,
    cjb_stack_arb_v_if.slave  bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    state_t     state;
    logic [2:0] cnt;
    logic       last;
    logic       ovf, unf;
    logic       pend, pend_id;

    logic       e0, e1, g0, g1, g_any;
    logic       gpush, gpop;
    logic [7:0] gdin;
    logic       do_push, do_pop, is_full, is_empty;

    always_comb begin
        e0 = bus.req0_push | bus.req0_pop;
        e1 = bus.req1_push | bus.req1_pop;
        g0 = 1'b0;
        g1 = 1'b0;
        if (state == RUN && !bus.flush) begin
            if (e0 && e1) begin
                g0 = last;
                g1 = ~last;
            end else begin
                g0 = e0;
                g1 = e1;
            end
        end
        g_any = g0 | g1;
        // push dominates pop when a requester asserts both
        gpush = g0 ? bus.req0_push : bus.req1_push;
        gpop  = g0 ? (bus.req0_pop & ~bus.req0_push) : (bus.req1_pop & ~bus.req1_push);
        gdin  = g0 ? bus.req0_din : bus.req1_din;
        is_full  = (cnt == DEPTH_C);
        is_empty = (cnt == 3'd0);
        do_push = g_any & gpush & ~is_full;
        do_pop  = g_any & gpop & ~is_empty;
    end

    assign bus.gnt0     = g0;
    assign bus.gnt1     = g1;
    assign bus.stk_push = do_push;
    assign bus.stk_pop  = do_pop;
    assign bus.stk_din  = do_push ? gdin : 8'h00;
    assign bus.stk_clr  = (state == INIT) | bus.flush;
    assign bus.rd_valid = pend;
    assign bus.rd_data  = pend ? bus.stk_dout : 8'h00;
    assign bus.rd_id    = pend_id;
    assign bus.count    = cnt;
    assign bus.full     = is_full;
    assign bus.empty    = is_empty;
    assign bus.ovf_err  = ovf;
    assign bus.unf_err  = unf;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= INIT;
            cnt     <= 3'd0;
            last    <= 1'b1;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            pend    <= 1'b0;
            pend_id <= 1'b0;
        end else begin
            pend <= do_pop;
            if (do_pop) pend_id <= g1;
            // a new error in the same cycle as err_clr keeps the flag set
            ovf <= (ovf & ~bus.err_clr) | (g_any & gpush & is_full);
            unf <= (unf & ~bus.err_clr) | (g_any & gpop & is_empty);
            case (state)
                INIT: begin
                    state <= RUN;
                    cnt   <= 3'd0;
                end
                RUN: begin
                    if (bus.flush)    cnt <= 3'd0;
                    else if (do_push) cnt <= cnt + 3'd1;
                    else if (do_pop)  cnt <= cnt - 3'd1;
                    if (g_any) last <= g1;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: doc/cjb_stack_arb_v.md
CJB_STACK_ARB_V -- requirements
Module: cjb_stack_arb_v

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of stack locations; the count width is fixed at 3 bits.
REQ-002 The block SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_push and req0_pop, each input, 1, level requests from requester 0.
REQ-005 The block SHALL have port req0_din, input, 8, push data from requester 0.
REQ-006 The block SHALL have ports req1_push, req1_pop and req1_din, matching the requester 0 ports, for requester 1.
REQ-007 The block SHALL have ports gnt0 and gnt1, each output, 1, one-cycle grant meaning the request is consumed this cycle.
REQ-008 The block SHALL have port flush, input, 1, synchronous request to empty the stack.
REQ-009 The block SHALL have ports stk_push and stk_pop, each output, 1, commands to the 8-bit stack.
REQ-010 The block SHALL have port stk_clr, output, 1, active-high synchronous clear to the stack.
REQ-011 The block SHALL have port stk_din, output, 8, push data to the stack.
REQ-012 The block SHALL have port stk_dout, input, 8, stack output, valid the cycle after a pop.
REQ-013 The block SHALL have ports rd_data (output, 8) and rd_valid (output, 1), the pop result.
REQ-014 The block SHALL have port rd_id, output, 1, the requester that owns rd_data.
REQ-015 The block SHALL have ports count (output, 3), full (output, 1) and empty (output, 1), giving occupancy.
REQ-016 The block SHALL have ports ovf_err and unf_err, each output, 1, sticky overflow and underflow flags, and port err_clr, input, 1, which clears them.

Function
REQ-017 The FSM SHALL have two states: INIT and RUN. INIT lasts exactly one cycle after Reset deasserts, driving stk_clr=1 with no grants, then moves to RUN.
REQ-018 In RUN, at most one request SHALL be granted per cycle. An eligible requester is one with push or pop asserted.
REQ-019 If exactly one requester is eligible, it SHALL be granted.
REQ-020 If both requesters are eligible, the one not granted last SHALL be granted (round-robin). The last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-021 If a requester asserts push and pop together, push SHALL win and pop is ignored for that grant.
REQ-022 The grant SHALL be combinational in the same cycle as the request. The requester may change its request the next cycle.
REQ-023 Granted push with count<DEPTH: stk_push=1 and stk_din=the granted din in the same cycle; count increments at the edge.
REQ-024 Granted push with count==DEPTH: the grant is still given, stk_push=0, count is unchanged, and ovf_err is set at the edge.
REQ-025 Granted pop with count>0: stk_pop=1 and count decrements at the edge. The next cycle, rd_valid=1, rd_data=stk_dout (pass-through), and rd_id=the granted requester.
REQ-026 Granted pop with count==0: the grant is given, stk_pop=0, rd_valid stays 0, and unf_err is set.
REQ-027 flush in RUN SHALL take priority over all requests: no grant, stk_clr=1, and count=0 at the edge. A pending rd_valid from the previous cycle's pop still completes.
REQ-028 Outside their asserted cycle, stk_push, stk_pop, stk_clr and rd_valid SHALL be 0, and stk_din and rd_data SHALL be 8'h00.
REQ-029 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both combinational from count.
REQ-030 err_clr SHALL clear both sticky flags at the edge. If err_clr and a new error occur in the same cycle, set wins.

Reset
REQ-031 While Reset=0, the following SHALL hold asynchronously: state=INIT, count=0, pointer=1, ovf_err=0, unf_err=0, rd_valid=0, gnt0=gnt1=0, stk_push=stk_pop=0, stk_clr=1, empty=1, full=0.
REQ-032 A Reset assertion in the middle of an operation SHALL abort it: no rd_valid is issued for a pop granted in the cycle before reset.

Verification
REQ-033 Reset release, then req0 pushes 8'hA1, 8'hB2, 8'hC3 -> one INIT cycle with stk_clr=1, three gnt0 pulses, count=3, empty=0.
REQ-034 Both requesters push every cycle for 4 cycles -> grants alternate 0,1,0,1; full=1 after the 4th; a 5th push gives a grant with stk_push=0 and ovf_err=1.
REQ-035 Pushes 8'h11 then 8'h22, then req1 pops twice -> rd_data=8'h22 then 8'h11, rd_id=1, and rd_valid is asserted one cycle after each gnt1.
REQ-036 Pop with count=0 -> gnt asserted, stk_pop=0, rd_valid=0, unf_err=1; err_clr -> unf_err=0 next cycle.
REQ-037 count=2 with flush and req0_push together -> no grant, stk_clr=1, count=0; the push is granted the next cycle and count=1.
REQ-038 Reset asserted the cycle after a pop grant -> rd_valid stays 0, and all outputs match the values in REQ-031.
